// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port memory with registered read.
// Define MEM_ARB_STATS_EN to add the saturating grant counters cnt_a/cnt_b.
module memory_arbiter #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_a,
   input  logic         we_a,
   input  logic [N-1:0] addr_a,
   input  logic [N-1:0] wdata_a,
   output logic         gnt_a,
   output logic         rvalid_a,
   output logic [N-1:0] rdata_a,
   input  logic         req_b,
   input  logic         we_b,
   input  logic [N-1:0] addr_b,
   input  logic [N-1:0] wdata_b,
   output logic         gnt_b,
   output logic         rvalid_b,
   output logic [N-1:0] rdata_b,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_write,
   input  logic [N-1:0] mem_read
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t state;
   logic   cmd_we;
   logic   owner;   // 0 = port A, 1 = port B
   logic   rr_ptr;  // port that wins a tie
   logic   win;

   assign win = (req_a && req_b) ? rr_ptr : req_b;

   // mem_addr/mem_write double as the latched command address and data:
   // they are loaded once per transaction and hold outside ISSUE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cmd_we    <= 1'b0;
         owner     <= 1'b0;
         rr_ptr    <= 1'b0;
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         rvalid_a  <= 1'b0;
         rvalid_b  <= 1'b0;
         rdata_a   <= '0;
         rdata_b   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_write <= '0;
      end else begin
         gnt_a    <= 1'b0;
         gnt_b    <= 1'b0;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
         mem_we   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  owner     <= win;
                  cmd_we    <= win ? we_b : we_a;
                  mem_we    <= win ? we_b : we_a;
                  mem_addr  <= win ? addr_b : addr_a;
                  mem_write <= win ? wdata_b : wdata_a;
                  gnt_a     <= ~win;
                  gnt_b     <= win;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               rr_ptr <= ~owner;
               state  <= cmd_we ? IDLE : WAIT;
            end
            WAIT: begin
               // memory returns data for the address issued in the previous cycle
               if (owner) begin
                  rdata_b  <= mem_read;
                  rvalid_b <= 1'b1;
               end else begin
                  rdata_a  <= mem_read;
                  rvalid_a <= 1'b1;
               end
               state <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (gnt_a && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + CNT_W'(1);
         if (gnt_b && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + CNT_W'(1);
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: randomized traffic against a reference memory array and
// latency/ordering rules, with a registered-read memory model attached to the mem_* pins.
`timescale 1ns/1ps
module tb_memory_arbiter;
   localparam int N     = 8;
   localparam int CNT_W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
   logic [N-1:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
   logic         gnt_a, rvalid_a, gnt_b, rvalid_b, mem_we;
   logic [N-1:0] rdata_a, rdata_b, mem_addr, mem_write;
   logic [N-1:0] mem_read = '0;
`ifdef MEM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a, cnt_b;
`endif

   int checks = 0;
   int fails  = 0;
   int protocol_errs = 0;
   logic [N-1:0] ram     [256];
   logic [N-1:0] ref_mem [256];

   always #5 clk = ~clk;

   memory_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read)
`ifdef MEM_ARB_STATS_EN
      , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
   );

   // single-port memory, registered read
   always @(posedge clk) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_write;
      mem_read <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (rst && ((gnt_a && gnt_b) || (rvalid_a && rvalid_b) || (mem_we && !(gnt_a || gnt_b))))
         protocol_errs++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_txn(input bit port, input bit we, input logic [N-1:0] addr, input logic [N-1:0] wdata,
                          output int gnt_lat, output int rv_lat, output logic [N-1:0] rdata,
                          output logic gnt_we, output logic [N-1:0] gnt_addr, output logic [N-1:0] gnt_wr,
                          output logic we_after);
      gnt_lat = -1; rv_lat = -1; rdata = '0; gnt_we = 1'b0; gnt_addr = '0; gnt_wr = '0; we_after = 1'b0;
      @(negedge clk);
      if (port) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
      else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if ((port ? gnt_b : gnt_a) === 1'b1) begin
            gnt_lat = c; gnt_we = mem_we; gnt_addr = mem_addr; gnt_wr = mem_write;
            break;
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      if (gnt_lat > 0) begin
         @(negedge clk);
         we_after = mem_we;
         if (!we) begin
            for (int c = 1; c <= 8; c++) begin
               if (c > 1) @(negedge clk);
               if ((port ? rvalid_b : rvalid_a) === 1'b1) begin
                  rv_lat = c; rdata = port ? rdata_b : rdata_a;
                  break;
               end
            end
         end
      end
      $display("txn port=%s we=%0b addr=%02h wdata=%02h gnt_lat=%0d rv_lat=%0d rdata=%02h",
               port ? "B" : "A", we, addr, wdata, gnt_lat, rv_lat, rdata);
   endtask

   task automatic test_reset();
      logic [4*N+4:0] outs;
      @(negedge clk);
      outs = {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_we, mem_addr, mem_write};
      checks++;
      if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
      req_a = 1'b1; req_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({gnt_a, gnt_b} !== 2'b00) begin fails++; $display("FAIL reset_no_grant: got %b want 00", {gnt_a, gnt_b}); end
      req_a = 1'b0; req_b = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic         cw [2];
      logic [N-1:0] ca [2], cd [2];
      logic [N-1:0] rd_exp = '0;
      logic [1:0]   rv_exp;
      int grants = 0, last = -100, gap = 0, exp_port = 0, rd_due = -1, rd_port = 0, p;
      for (int i = 0; i < 2; i++) begin cw[i] = 1'($urandom_range(0, 1)); ca[i] = N'($urandom); cd[i] = N'($urandom); end
      @(negedge clk);
      req_a = 1'b1; we_a = cw[0]; addr_a = ca[0]; wdata_a = cd[0];
      req_b = 1'b1; we_b = cw[1]; addr_b = ca[1]; wdata_b = cd[1];
      for (int c = 0; c < 150 && (grants < 12 || c <= rd_due); c++) begin
         @(negedge clk);
         rv_exp = (c == rd_due) ? (rd_port == 1 ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({rvalid_a, rvalid_b} !== rv_exp) begin
            fails++; $display("FAIL rr_rvalid: cycle %0d got %b want %b", c, {rvalid_a, rvalid_b}, rv_exp);
         end
         if (c == rd_due) begin
            checks++;
            if ((rd_port == 1 ? rdata_b : rdata_a) !== rd_exp) begin
               fails++; $display("FAIL rr_rdata: got %h want %h", rd_port == 1 ? rdata_b : rdata_a, rd_exp);
            end
         end
         if (gnt_a || gnt_b) begin
            p = gnt_b ? 1 : 0;
            checks++;
            if (p != exp_port || (gnt_a && gnt_b)) begin
               fails++; $display("FAIL rr_order: grant %0d got gnt_a=%b gnt_b=%b want port %0d", grants, gnt_a, gnt_b, exp_port);
            end
            if (grants > 0) begin
               checks++;
               if (c - last != gap) begin fails++; $display("FAIL rr_spacing: got %0d cycles want %0d", c - last, gap); end
            end
            $display("txn port=%s we=%0b addr=%02h wdata=%02h (contended)", p == 1 ? "B" : "A", cw[p], ca[p], cd[p]);
            if (cw[p]) begin
               ref_mem[ca[p]] = cd[p]; gap = 2;
            end else begin
               rd_port = p; rd_exp = ref_mem[ca[p]]; rd_due = c + 2; gap = 4;
            end
            last = c; grants++; exp_port = 1 - p;
            if (grants >= 12) begin
               req_a = 1'b0; req_b = 1'b0;
            end else begin
               cw[p] = 1'($urandom_range(0, 1)); ca[p] = N'($urandom); cd[p] = N'($urandom);
               if (p == 1) begin we_b = cw[1]; addr_b = ca[1]; wdata_b = cd[1]; end
               else        begin we_a = cw[0]; addr_a = ca[0]; wdata_a = cd[0]; end
            end
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      checks++;
      if (grants != 12) begin fails++; $display("FAIL rr_grant_count: got %0d want 12", grants); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_b();
      int gl, rl; logic [N-1:0] rd, ga, gd; logic gw, wa;
      logic [N-1:0] a = N'($urandom), d = N'($urandom);
      run_txn(1, 1, a, d, gl, rl, rd, gw, ga, gd, wa);
      ref_mem[a] = d;
      checks++;
      if (gl != 1) begin fails++; $display("FAIL single_b_write_lat: got %0d want 1", gl); end
      run_txn(1, 0, a, '0, gl, rl, rd, gw, ga, gd, wa);
      checks++;
      if (gl != 1 || rl != 2) begin fails++; $display("FAIL single_b_read_lat: got gnt %0d rv %0d want 1 2", gl, rl); end
      checks++;
      if (rd !== ref_mem[a]) begin fails++; $display("FAIL single_b_rdata: got %h want %h", rd, ref_mem[a]); end
   endtask

   task automatic test_write_read();
      int gl, rl; logic [N-1:0] rd, ga, gd; logic gw, wa;
      run_txn(0, 1, 8'h05, 8'hA5, gl, rl, rd, gw, ga, gd, wa);
      ref_mem[8'h05] = 8'hA5;
      checks++;
      if (gl != 1) begin fails++; $display("FAIL wr_gnt_lat: got %0d want 1", gl); end
      checks++;
      if ({gw, ga, gd} !== {1'b1, 8'h05, 8'hA5}) begin
         fails++; $display("FAIL wr_mem_pins: got we=%b addr=%h data=%h want 1 05 a5", gw, ga, gd);
      end
      checks++;
      if (wa !== 1'b0) begin fails++; $display("FAIL wr_we_pulse: mem_we after issue got %b want 0", wa); end
      run_txn(0, 0, 8'h05, '0, gl, rl, rd, gw, ga, gd, wa);
      checks++;
      if (gl != 1 || rl != 2 || gw !== 1'b0) begin
         fails++; $display("FAIL rd_latency: got gnt %0d rv %0d we %b want 1 2 0", gl, rl, gw);
      end
      checks++;
      if (rd !== 8'hA5) begin fails++; $display("FAIL rd_data: got %h want a5", rd); end
      run_txn(1, 1, 8'h07, 8'h3C, gl, rl, rd, gw, ga, gd, wa);
      ref_mem[8'h07] = 8'h3C;
      checks++;
      if (rdata_a !== 8'hA5) begin fails++; $display("FAIL rdata_hold: got %h want a5", rdata_a); end
   endtask

   task automatic test_withdraw();
      int seen = 0;
      @(negedge clk);
      req_b = 1'b1; we_b = 1'b0; addr_b = 8'h10;
      @(negedge clk);
      req_b = 1'b0;
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h10; wdata_a = 8'hEE;
      @(negedge clk);
      req_a = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (gnt_a) seen++;
      end
      checks++;
      if (seen != 0) begin fails++; $display("FAIL withdraw: got %0d grants to A want 0", seen); end
   endtask

   task automatic test_fill();
      int gl, rl; logic [N-1:0] rd, ga, gd, a; logic gw, wa;
      for (int i = 0; i < 256; i++) begin
         a = N'(i);
         run_txn(a[0], 1, a, a, gl, rl, rd, gw, ga, gd, wa);
         ref_mem[a] = a;
         checks++;
         if (gl != 1) begin fails++; $display("FAIL fill_write_lat: addr %h got %0d want 1", a, gl); end
      end
      for (int i = 0; i < 256; i++) begin
         a = N'(i);
         run_txn(~a[0], 0, a, '0, gl, rl, rd, gw, ga, gd, wa);
         checks++;
         if (rl != 2 || rd !== a) begin fails++; $display("FAIL fill_readback: addr %h got %h lat %0d want %h lat 2", a, rd, rl, a); end
      end
   endtask

   task automatic test_random();
      int gl, rl; logic [N-1:0] rd, ga, gd, a, d; logic gw, wa; bit p, w;
      for (int i = 0; i < 150; i++) begin
         p = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
         a = N'($urandom_range(0, 15)); d = N'($urandom);
         run_txn(p, w, a, d, gl, rl, rd, gw, ga, gd, wa);
         if (w) begin
            ref_mem[a] = d;
            checks++;
            if (gl != 1 || {gw, ga, gd} !== {1'b1, a, d}) begin
               fails++; $display("FAIL rand_write: got lat %0d we=%b addr=%h data=%h want 1 1 %h %h", gl, gw, ga, gd, a, d);
            end
         end else begin
            checks++;
            if (gl != 1 || rl != 2 || rd !== ref_mem[a]) begin
               fails++; $display("FAIL rand_read: addr %h got %h lat %0d/%0d want %h lat 1/2", a, rd, gl, rl, ref_mem[a]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int gl, rl; logic [N-1:0] rd, ga, gd; logic gw, wa;
      logic [4*N+4:0] outs;
      logic we_before;
      run_txn(1, 0, 8'h06, '0, gl, rl, rd, gw, ga, gd, wa);
      run_txn(0, 0, 8'h05, '0, gl, rl, rd, gw, ga, gd, wa);
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h33; wdata_a = 8'h99;
      @(negedge clk);
      we_before = mem_we;
      #1 rst = 1'b0;
      #1;
      outs = {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_we, mem_addr, mem_write};
      checks++;
      if (we_before !== 1'b1 || outs !== '0) begin
         fails++; $display("FAIL reset_async: mem_we before %b, outputs got %h want 0", we_before, outs);
      end
      req_a = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h33; wdata_a = 8'h3C;
      req_b = 1'b1; we_b = 1'b1; addr_b = 8'h34; wdata_b = 8'h44;
      @(negedge clk);
      checks++;
      if ({gnt_a, gnt_b} !== 2'b10) begin fails++; $display("FAIL reset_rr_ptr: got gnt %b want 10", {gnt_a, gnt_b}); end
      req_a = 1'b0; req_b = 1'b0;
      ref_mem[8'h33] = 8'h3C;
      repeat (3) @(negedge clk);
      run_txn(1, 0, 8'h33, '0, gl, rl, rd, gw, ga, gd, wa);
      checks++;
      if (rd !== 8'h3C) begin fails++; $display("FAIL reset_rewrite: got %h want 3c", rd); end
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic test_stats();
      int gl, rl; logic [N-1:0] rd, ga, gd; logic gw, wa;
      longint maxv = (longint'(1) << CNT_W) - 1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      checks++;
      if ({cnt_a, cnt_b} !== '0) begin fails++; $display("FAIL stats_reset: got %h %h want 0 0", cnt_a, cnt_b); end
      for (int i = 0; i < 13; i++) begin
         run_txn(i >= 10, 1, N'(i + 64), N'(i), gl, rl, rd, gw, ga, gd, wa);
         ref_mem[N'(i + 64)] = N'(i);
      end
      checks++;
      if (cnt_a !== CNT_W'((10 > maxv) ? maxv : 10) || cnt_b !== CNT_W'((3 > maxv) ? maxv : 3)) begin
         fails++; $display("FAIL stats_count: got %0d %0d want 10 3 (saturated at %0d)", cnt_a, cnt_b, maxv);
      end
   endtask
`endif

   task automatic test_protocol();
      checks++;
      if (protocol_errs != 0) begin fails++; $display("FAIL protocol: got %0d overlap/we violations want 0", protocol_errs); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
      #2 rst = 1'b0;
      test_reset();
      test_round_robin();
      test_single_b();
      test_write_read();
      test_withdraw();
      test_fill();
      test_random();
      test_reset_mid();
`ifdef MEM_ARB_STATS_EN
      test_stats();
`endif
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
